// File: rtl/rv32i_pkg.sv
// Shared RV32I execute-stage encodings: ALU control, forwarding selects,
// branch funct3 codes and the EX/MEM pipeline register layout.
package rv32i_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [1:0] FWD_REG     = 2'b00;
    localparam logic [1:0] FWD_RESULTW = 2'b01;
    localparam logic [1:0] FWD_ALURESM = 2'b10;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic [1:0]  result_src;
        logic [1:0]  mem_size;
        logic [4:0]  rd;
        logic [31:0] alu_result;
        logic [31:0] write_data;
        logic [31:0] pc_plus4;
    } exmem_t;

    function automatic logic is_shift_op(input logic [3:0] ctrl);
        logic res;
        case (ctrl)
            ALU_SLL, ALU_SRL, ALU_SRA: res = 1'b1;
            default:                   res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/exec_stage_if.sv
// ID/EX inputs, forwarding inputs and EX/MEM outputs of the execute stage.
// The slave modport is the execute stage; the master side is the pipeline around it.
interface exec_stage_if;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE;
    logic [1:0]  ResultSrcE, MemSizeE, ForwardAE, ForwardBE;
    logic [3:0]  ALUCtrlE;
    logic [2:0]  Funct3E;
    logic [4:0]  RdE;
    logic [31:0] RD1E, RD2E, PCE, ExtImmE, PCPlus4E, ResultW;

    logic        PCSrcE, BusyE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM, MemSizeM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    modport master (
        output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE,
               ResultSrcE, MemSizeE, ForwardAE, ForwardBE, ALUCtrlE, Funct3E,
               RdE, RD1E, RD2E, PCE, ExtImmE, PCPlus4E, ResultW,
        input  PCSrcE, BusyE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM,
               MemSizeM, RdM, ALUResultM, WriteDataM, PCPlus4M
    );

    modport slave (
        input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JalrE,
               ResultSrcE, MemSizeE, ForwardAE, ForwardBE, ALUCtrlE, Funct3E,
               RdE, RD1E, RD2E, PCE, ExtImmE, PCPlus4E, ResultW,
        output PCSrcE, BusyE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM,
               MemSizeM, RdM, ALUResultM, WriteDataM, PCPlus4M
    );
endinterface

// File: rtl/serial_shifter.sv
// One-bit-per-cycle shifter for SLL/SRL/SRA; operands and op are latched on
// entry so upstream forwarding may change while the shift is in flight.
module serial_shifter
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [3:0]  op_i,
    input  logic [31:0] operand_i,
    input  logic [4:0]  shamt_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;

    // Next-state, accumulator and stall request
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i && (shamt_i != 5'd0)) begin
                    busy_o  = 1'b1;
                    state_d = SHIFT;
                    acc_d   = operand_i;
                    cnt_d   = shamt_i;
                    op_d    = op_i;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                if (cnt_q != 5'd0) begin
                    busy_o = 1'b1;
                    cnt_d  = cnt_q - 5'd1;
                    case (op_q)
                        ALU_SLL: acc_d = {acc_q[30:0], 1'b0};
                        ALU_SRL: acc_d = {1'b0, acc_q[31:1]};
                        ALU_SRA: acc_d = {acc_q[31], acc_q[31:1]};
                        default: acc_d = acc_q;
                    endcase
                end else begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shifter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= 32'd0;
            cnt_q   <= 5'd0;
            op_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    assign result_o = acc_q;

endmodule

// File: rtl/exec_stage.sv
// RV32I execute stage: forwarding, ALU, branch resolution and EX/MEM register.
// Define EXEC_BARREL_SHIFT_EN for single-cycle shifts; otherwise shifts are serial.
module exec_stage
    import rv32i_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    exec_stage_if.slave  bus
);
    exmem_t      exmem_q, exmem_d;
    logic [31:0] src_a_s, fwd_b_s, src_b_s, alu_result_s, pc_target_s, jalr_sum_s;
    logic        busy_s, shift_done_s, cond_s;
    logic [31:0] shift_result_s;

`ifdef EXEC_BARREL_SHIFT_EN
    assign busy_s         = 1'b0;
    assign shift_done_s   = 1'b0;
    assign shift_result_s = 32'd0;
`else
    logic is_shift_s;
    assign is_shift_s = is_shift_op(bus.ALUCtrlE);

    serial_shifter u_shifter (
        .clk       (clk),
        .rst       (rst),
        .start_i   (is_shift_s),
        .op_i      (bus.ALUCtrlE),
        .operand_i (src_a_s),
        .shamt_i   (src_b_s[4:0]),
        .busy_o    (busy_s),
        .done_o    (shift_done_s),
        .result_o  (shift_result_s)
    );
`endif

    // Operand forwarding; code 11 falls back to the register file value
    always_comb begin
        case (bus.ForwardAE)
            FWD_RESULTW: src_a_s = bus.ResultW;
            FWD_ALURESM: src_a_s = exmem_q.alu_result;
            default:     src_a_s = bus.RD1E;
        endcase
        case (bus.ForwardBE)
            FWD_RESULTW: fwd_b_s = bus.ResultW;
            FWD_ALURESM: fwd_b_s = exmem_q.alu_result;
            default:     fwd_b_s = bus.RD2E;
        endcase
        if (bus.ALUSrcE) begin
            src_b_s = bus.ExtImmE;
        end else begin
            src_b_s = fwd_b_s;
        end
    end

    // ALU; a finished serial shift overrides the decoded operation
    always_comb begin
        alu_result_s = 32'd0;
        if (shift_done_s) begin
            alu_result_s = shift_result_s;
        end else begin
            case (bus.ALUCtrlE)
                ALU_ADD:   alu_result_s = src_a_s + src_b_s;
                ALU_SUB:   alu_result_s = src_a_s - src_b_s;
                ALU_AND:   alu_result_s = src_a_s & src_b_s;
                ALU_OR:    alu_result_s = src_a_s | src_b_s;
                ALU_XOR:   alu_result_s = src_a_s ^ src_b_s;
                ALU_SLT:   alu_result_s = {31'd0, $signed(src_a_s) < $signed(src_b_s)};
                ALU_SLTU:  alu_result_s = {31'd0, src_a_s < src_b_s};
                ALU_PASSB: alu_result_s = src_b_s;
`ifdef EXEC_BARREL_SHIFT_EN
                ALU_SLL:   alu_result_s = src_a_s << src_b_s[4:0];
                ALU_SRL:   alu_result_s = src_a_s >> src_b_s[4:0];
                ALU_SRA:   alu_result_s = $unsigned($signed(src_a_s) >>> src_b_s[4:0]);
`else
                // Only a zero-length shift reaches here without stalling
                ALU_SLL, ALU_SRL, ALU_SRA: alu_result_s = src_a_s;
`endif
                default:   alu_result_s = 32'd0;
            endcase
        end
    end

    // Branch condition and jump/branch target
    always_comb begin
        case (bus.Funct3E)
            F3_BEQ:  cond_s = (src_a_s == fwd_b_s);
            F3_BNE:  cond_s = (src_a_s != fwd_b_s);
            F3_BLT:  cond_s = ($signed(src_a_s) <  $signed(fwd_b_s));
            F3_BGE:  cond_s = ($signed(src_a_s) >= $signed(fwd_b_s));
            F3_BLTU: cond_s = (src_a_s <  fwd_b_s);
            F3_BGEU: cond_s = (src_a_s >= fwd_b_s);
            default: cond_s = 1'b0;
        endcase
        jalr_sum_s = src_a_s + bus.ExtImmE;
        if (bus.JalrE) begin
            pc_target_s = {jalr_sum_s[31:1], 1'b0};
        end else begin
            pc_target_s = bus.PCE + bus.ExtImmE;
        end
    end

    // EX/MEM next value: bubble while stalled
    always_comb begin
        exmem_d = '0;
        if (busy_s) begin
            exmem_d = '0;
        end else begin
            exmem_d.reg_write  = bus.RegWriteE;
            exmem_d.mem_write  = bus.MemWriteE;
            exmem_d.result_src = bus.ResultSrcE;
            exmem_d.mem_size   = bus.MemSizeE;
            exmem_d.rd         = bus.RdE;
            exmem_d.alu_result = alu_result_s;
            exmem_d.write_data = fwd_b_s;
            exmem_d.pc_plus4   = bus.PCPlus4E;
        end
    end

    // EX/MEM pipeline register
    always_ff @(posedge clk) begin
        if (rst) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign bus.PCSrcE     = ~busy_s & (bus.JumpE | (bus.BranchE & cond_s));
    assign bus.PCTargetE  = pc_target_s;
    assign bus.BusyE      = busy_s;
    assign bus.RegWriteM  = exmem_q.reg_write;
    assign bus.MemWriteM  = exmem_q.mem_write;
    assign bus.ResultSrcM = exmem_q.result_src;
    assign bus.MemSizeM   = exmem_q.mem_size;
    assign bus.RdM        = exmem_q.rd;
    assign bus.ALUResultM = exmem_q.alu_result;
    assign bus.WriteDataM = exmem_q.write_data;
    assign bus.PCPlus4M   = exmem_q.pc_plus4;

endmodule

// File: tb/tb_exec_stage.sv
// Directed and random checks of exec_stage against an instruction-level
// reference model (forwarding, ALU, branch, stall length, EX/MEM contents).
module tb_exec_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] m_alu_m = 32'd0;

    always #5 clk = ~clk;

    exec_stage_if bus ();

    exec_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        rw, mw, jump, branch, alusrc, jalr;
        logic [1:0]  rsrc, msize, fa, fb;
        logic [3:0]  ctrl;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] rd1, rd2, pc, imm, pcp4, resw;
    } instr_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic instr_t bubble();
        instr_t t;
        t.rw = 1'b0; t.mw = 1'b0; t.jump = 1'b0; t.branch = 1'b0; t.alusrc = 1'b0; t.jalr = 1'b0;
        t.rsrc = 2'd0; t.msize = 2'd0; t.fa = 2'd0; t.fb = 2'd0;
        t.ctrl = 4'd0; t.f3 = 3'd0; t.rd = 5'd0;
        t.rd1 = 32'd0; t.rd2 = 32'd0; t.pc = 32'd0; t.imm = 32'd0; t.pcp4 = 32'd0; t.resw = 32'd0;
        return t;
    endfunction

    task automatic apply(input instr_t t);
        bus.RegWriteE = t.rw;   bus.MemWriteE = t.mw;     bus.JumpE = t.jump;
        bus.BranchE   = t.branch; bus.ALUSrcE = t.alusrc; bus.JalrE = t.jalr;
        bus.ResultSrcE = t.rsrc; bus.MemSizeE = t.msize;
        bus.ForwardAE  = t.fa;   bus.ForwardBE = t.fb;
        bus.ALUCtrlE   = t.ctrl; bus.Funct3E = t.f3; bus.RdE = t.rd;
        bus.RD1E = t.rd1; bus.RD2E = t.rd2; bus.PCE = t.pc;
        bus.ExtImmE = t.imm; bus.PCPlus4E = t.pcp4; bus.ResultW = t.resw;
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] regv,
                                         input logic [31:0] resw, input logic [31:0] alum);
        if (sel == 2'b01) return resw;
        if (sel == 2'b10) return alum;
        return regv;
    endfunction

    function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6:  return (a < b) ? 32'd1 : 32'd0;
            7:  return a << sh;
            8:  return a >> sh;
            9:  return 32'(int'(a) >>> sh);
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_cond(input int f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            0: return a == b;
            1: return a != b;
            4: return int'(a) <  int'(b);
            5: return int'(a) >= int'(b);
            6: return a <  b;
            7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Issue one instruction starting just after a rising edge; returns just after its capture edge.
    task automatic exec_one(input string nm, input instr_t t);
        logic [31:0] a, fb, b, res, tgt;
        logic        psrc, is_sh;
        int          nbusy;
        a     = pick(t.fa, t.rd1, t.resw, m_alu_m);
        fb    = pick(t.fb, t.rd2, t.resw, m_alu_m);
        b     = t.alusrc ? t.imm : fb;
        res   = ref_alu(int'(t.ctrl), a, b);
        tgt   = t.jalr ? ((a + t.imm) & 32'hFFFF_FFFE) : (t.pc + t.imm);
        psrc  = t.jump | (t.branch & ref_cond(int'(t.f3), a, fb));
        is_sh = (t.ctrl >= 4'd7) && (t.ctrl <= 4'd9);
`ifdef EXEC_BARREL_SHIFT_EN
        nbusy = 0;
`else
        nbusy = (is_sh && (b % 32 != 0)) ? int'(b % 32) + 1 : 0;
`endif
        apply(t);
        @(negedge clk);
        chk({nm, ".PCTargetE"}, bus.PCTargetE, tgt);
        for (int c = 0; c < nbusy; c++) begin
            chk({nm, ".BusyE(stall)"}, {31'd0, bus.BusyE}, 32'd1);
            chk({nm, ".PCSrcE(stall)"}, {31'd0, bus.PCSrcE}, 32'd0);
            @(posedge clk); #1;
            chk({nm, ".bubble.RegWriteM"}, {31'd0, bus.RegWriteM}, 32'd0);
            chk({nm, ".bubble.RdM"}, {27'd0, bus.RdM}, 32'd0);
            chk({nm, ".bubble.ALUResultM"}, bus.ALUResultM, 32'd0);
            m_alu_m = 32'd0;
            bus.RD1E = $urandom;
            @(negedge clk);
        end
        chk({nm, ".BusyE"}, {31'd0, bus.BusyE}, 32'd0);
        chk({nm, ".PCSrcE"}, {31'd0, bus.PCSrcE}, {31'd0, psrc});
        @(posedge clk); #1;
        chk({nm, ".ALUResultM"}, bus.ALUResultM, res);
        chk({nm, ".WriteDataM"}, bus.WriteDataM, fb);
        chk({nm, ".RdM"}, {27'd0, bus.RdM}, {27'd0, t.rd});
        chk({nm, ".PCPlus4M"}, bus.PCPlus4M, t.pcp4);
        chk({nm, ".ctrlM"}, {26'd0, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.MemSizeM},
            {26'd0, t.rw, t.mw, t.rsrc, t.msize});
        m_alu_m = res;
    endtask

    initial begin
        instr_t t;
        t = bubble();
        apply(t);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ALUResultM", bus.ALUResultM, 32'd0);
        chk("reset.ctrlM", {25'd0, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.MemSizeM, 1'b0},
            32'd0);
        chk("reset.RdM", {27'd0, bus.RdM}, 32'd0);
        chk("reset.WriteDataM", bus.WriteDataM, 32'd0);
        chk("reset.PCPlus4M", bus.PCPlus4M, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset.BusyE", {31'd0, bus.BusyE}, 32'd0);
        chk("post_reset.PCSrcE", {31'd0, bus.PCSrcE}, 32'd0);
        @(posedge clk); #1;
        m_alu_m = 32'd0;

        t = bubble(); t.ctrl = 4'b0000; t.rd1 = 32'd5; t.rd2 = 32'd7; t.rd = 5'd3; t.rw = 1'b1;
        exec_one("add", t);
        chk("add.ALUResultM=12", bus.ALUResultM, 32'd12);

        t = bubble(); t.ctrl = 4'b0000; t.rd1 = 32'd60; t.rd2 = 32'd40; t.rd = 5'd4;
        exec_one("add100", t);
        t = bubble(); t.ctrl = 4'b0001; t.fa = 2'b10; t.fb = 2'b01; t.resw = 32'd1; t.rd = 5'd5;
        exec_one("sub_fwd", t);
        chk("sub_fwd.ALUResultM=99", bus.ALUResultM, 32'd99);

        t = bubble(); t.ctrl = 4'b0001; t.branch = 1'b1; t.f3 = 3'b100;
        t.rd1 = 32'hFFFF_FFFF; t.rd2 = 32'd1; t.pc = 32'h100; t.imm = 32'h20;
        exec_one("blt", t);
        t.f3 = 3'b110;
        exec_one("bltu", t);

        t = bubble(); t.ctrl = 4'b0000; t.jump = 1'b1; t.jalr = 1'b1; t.alusrc = 1'b1;
        t.rd1 = 32'h203; t.imm = 32'd0; t.pc = 32'h100; t.pcp4 = 32'h104; t.rd = 5'd1; t.rw = 1'b1;
        exec_one("jalr", t);

        t = bubble(); t.ctrl = 4'b1001; t.alusrc = 1'b1; t.imm = 32'd4; t.rd1 = 32'h8000_0000;
        t.rd = 5'd6; t.rw = 1'b1;
        exec_one("sra4", t);
        chk("sra4.ALUResultM=F8000000", bus.ALUResultM, 32'hF800_0000);

        t = bubble(); t.ctrl = 4'b0111; t.alusrc = 1'b1; t.imm = 32'd0; t.rd1 = 32'h1234_5678;
        exec_one("sll0", t);

        // Reset while the shifter has two steps left
        t = bubble(); t.ctrl = 4'b1001; t.alusrc = 1'b1; t.imm = 32'd4; t.rd1 = 32'h8000_0000;
        t.rd = 5'd7; t.rw = 1'b1;
        apply(t);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        apply(bubble());
        @(posedge clk); #1;
        chk("rst_shift.BusyE", {31'd0, bus.BusyE}, 32'd0);
        chk("rst_shift.ALUResultM", bus.ALUResultM, 32'd0);
        chk("rst_shift.ctrlM", {27'd0, bus.RegWriteM, bus.MemWriteM, bus.ResultSrcM, bus.MemSizeM}, 32'd0);
        chk("rst_shift.RdM", {27'd0, bus.RdM}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_shift.idle.BusyE", {31'd0, bus.BusyE}, 32'd0);
        chk("rst_shift.idle.PCSrcE", {31'd0, bus.PCSrcE}, 32'd0);
        @(posedge clk); #1;
        m_alu_m = 32'd0;

        for (int i = 0; i < 40; i++) begin
            t.rw = 1'($urandom); t.mw = 1'($urandom); t.jump = 1'($urandom); t.branch = 1'($urandom);
            t.alusrc = 1'($urandom); t.jalr = 1'($urandom);
            t.rsrc = 2'($urandom); t.msize = 2'($urandom); t.fa = 2'($urandom); t.fb = 2'($urandom);
            t.ctrl = 4'($urandom_range(0, 15)); t.f3 = 3'($urandom); t.rd = 5'($urandom);
            t.rd1 = $urandom; t.rd2 = $urandom; t.pc = $urandom; t.imm = $urandom;
            t.pcp4 = $urandom; t.resw = $urandom;
            if ($urandom_range(0, 2) == 0) t.rd2 = t.rd1;
            if ($urandom_range(0, 3) == 0) t.imm = 32'($urandom_range(0, 31));
            if ((t.ctrl >= 4'd7) && (t.ctrl <= 4'd9)) begin
                t.jump = 1'b0; t.branch = 1'b0;
                if (t.fb == 2'b10) t.fb = 2'b00;
            end
            exec_one($sformatf("rand%0d", i), t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have inputs from the ID/EX register: RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE (1 each); ResultSrcE, MemSizeE (2 each); ALUCtrlE (4); RdE (5); RD1E, RD2E, PCE, ExtImmE, PCPlus4E (32 each).
REQ-004 SHALL have inputs JalrE  in  1  (JALR indicator) and Funct3E  in  3  (branch condition).
REQ-005 SHALL have inputs ForwardAE, ForwardBE  in  2  (operand select) and ResultW  in  32  (writeback value).
REQ-006 SHALL have outputs PCSrcE  out  1, PCTargetE  out  32, BusyE  out  1 (stall request to the hazard unit).
REQ-007 SHALL have registered EX/MEM outputs: RegWriteM, MemWriteM (1); ResultSrcM, MemSizeM (2); RdM (5); ALUResultM, WriteDataM, PCPlus4M (32).

Function
REQ-008 SHALL select SrcAE and the forwarded B value by the select code: 00 RD1E/RD2E, 01 ResultW, 10 ALUResultM, 11 treated as 00.
REQ-009 SHALL use SrcBE = ExtImmE when ALUSrcE=1, else the forwarded B value; WriteDataM SHALL capture the forwarded B value.
REQ-010 SHALL compute ADD, SUB, AND, OR, XOR, SLT (signed), SLTU, SLL, SRL, SRA, PASSB; shift amount = SrcBE[4:0]; arithmetic modulo 2^32, no overflow flag.
REQ-011 SHALL resolve branches combinationally: Funct3E 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU on SrcAE vs forwarded B; 010/011 never taken.
REQ-012 SHALL drive PCSrcE = JumpE OR (BranchE AND condition true); PCSrcE SHALL be 0 while the shifter is mid-operation.
REQ-013 SHALL drive PCTargetE = (SrcAE + ExtImmE) with bit 0 cleared when JalrE=1, else PCE + ExtImmE.
REQ-014 SHALL have single-cycle latency for all non-shift operations: the EX/MEM register captures on the next edge.
REQ-015 SHALL implement the shifter (without macro) as FSM IDLE/SHIFT: in IDLE with a shift op and shamt N>0, BusyE=1 and the next edge loads acc=SrcAE, cnt=N, and enters SHIFT.
REQ-016 SHALL, in SHIFT with cnt!=0, hold BusyE=1 and shift acc by one bit per edge (SRA replicates bit 31) while decrementing cnt.
REQ-017 SHALL, in SHIFT with cnt=0, drive BusyE=0 and ALU result = acc, capture into EX/MEM on that edge, and return to IDLE; a shift of N>0 stalls N+1 cycles.
REQ-018 SHALL treat a shift with N=0 as single-cycle with result SrcAE and BusyE=0.
REQ-019 SHALL load a bubble into EX/MEM (RegWriteM=0, MemWriteM=0, RdM=0, other fields 0) on every edge where BusyE=1.
REQ-020 SHALL ignore RD1E/RD2E/ForwardAE/ForwardBE changes while in SHIFT; the operands latched at entry are used.

Reset
REQ-021 SHALL, on an edge with rst=1, clear every EX/MEM output to 0, the FSM to IDLE, acc and cnt to 0, overriding any in-flight shift.
REQ-022 SHALL drive BusyE=0 and PCSrcE=0 in the cycle after reset when the inputs present a bubble.

Configuration
REQ-023 SHALL, with EXEC_BARREL_SHIFT_EN defined, implement shifts as a single-cycle barrel shifter; the FSM is absent and BusyE is tied to 0.
REQ-024 SHALL, with EXEC_BARREL_SHIFT_EN undefined, use the serial shifter of REQ-015..REQ-020.

Structure
REQ-025 SHALL take ALUCtrl encodings (ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLT 0101, SLTU 0110, SLL 0111, SRL 1000, SRA 1001, PASSB 1010), forward-select codes and branch funct3 codes from shared package rv32i_pkg.
REQ-026 SHALL place the serial shift FSM in one sub-module, serial_shifter; ALU, compare and EX/MEM register stay in exec_stage.

Verification
REQ-027 SHALL cover: ADD, RD1E=5, RD2E=7, ALUSrcE=0, RdE=3 -> next edge ALUResultM=12, RdM=3, BusyE=0 throughout.
REQ-028 SHALL cover: ForwardAE=10, ALUResultM=100, ForwardBE=01, ResultW=1, SUB -> ALUResultM=99.
REQ-029 SHALL cover: BLT, RD1E=0xFFFFFFFF, RD2E=1, PCE=0x100, ExtImmE=0x20 -> PCSrcE=1, PCTargetE=0x120; same with BLTU -> PCSrcE=0.
REQ-030 SHALL cover: JALR, RD1E=0x203, ExtImmE=0 -> PCTargetE=0x202, PCSrcE=1, ALUResultM ignored, PCPlus4M captured.
REQ-031 SHALL cover (serial): SRA, RD1E=0x80000000, shamt=4 -> BusyE=1 for 5 cycles, bubbles in EX/MEM, then ALUResultM=0xF8000000.
REQ-032 SHALL cover: rst asserted in SHIFT with cnt=2 -> next edge FSM IDLE, BusyE=0, all EX/MEM outputs 0.
